enc4_2_capture: RTL and testbench

//  Registered 4-to-2 encoder, the inverse of the 2-to-4 decoder path.
//  - Detects newly asserted request lines I3..I0 and encodes them to a 2-bit code A1/A0.
//  - Applies the same enable pair as the decoder: E1 active high, E0_L active low.
//  - Holds each captured code with VALID until the consumer accepts it with READY.
//  - Flags multi-hot captures and requests lost while a code is waiting.

---
 rtl/enc4_2_capture.sv | 116 +++++++++++
 tb/tb_enc4_2_capture.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/enc4_2_capture.sv
// Registered 4-to-2 encoder: captures rising request edges while enabled and
// holds the encoded index with VALID until the consumer accepts it with READY.
module enc4_2_capture #(
    parameter bit PRIORITY_HIGH = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             E1,
    input  logic             E0_L,
    input  logic             I3,
    input  logic             I2,
    input  logic             I1,
    input  logic             I0,
    input  logic             READY,
    output logic             A1,
    output logic             A0,
    output logic             VALID,
    output logic             MULTI,
    output logic             OVR,
    output logic [CNT_W-1:0] COUNT
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [3:0]       r_iPrev;
    logic [1:0]       r_code;
    logic             r_multi;
    logic             r_ovr;
    logic [CNT_W-1:0] r_count;

    logic             w_en;
    logic [3:0]       w_req;
    logic [3:0]       w_edge;
    logic             w_any;
    logic             w_multi;
    logic [1:0]       w_code;

    assign w_en    = E1 & ~E0_L;
    assign w_req   = {I3, I2, I1, I0};
    assign w_edge  = w_req & ~r_iPrev & {4{w_en}};
    assign w_any   = |w_edge;
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign w_multi = |(w_edge & 4'(w_edge - 4'd1));

    always_comb begin
        w_code = 2'd0;
        if (PRIORITY_HIGH) begin
            if (w_edge[3])      w_code = 2'd3;
            else if (w_edge[2]) w_code = 2'd2;
            else if (w_edge[1]) w_code = 2'd1;
            else                w_code = 2'd0;
        end else begin
            if (w_edge[0])      w_code = 2'd0;
            else if (w_edge[1]) w_code = 2'd1;
            else if (w_edge[2]) w_code = 2'd2;
            else if (w_edge[3]) w_code = 2'd3;
            else                w_code = 2'd0;
        end
    end

    // Request history tracks the raw lines every cycle, so edges seen while disabled are lost.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_iPrev <= 4'b0000;
        end else begin
            r_iPrev <= w_req;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state <= S_IDLE;
            r_code  <= 2'd0;
            r_multi <= 1'b0;
            r_ovr   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_code  <= w_code;
                        r_multi <= w_multi;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // An accept wins over a coincident edge: that edge becomes the next capture.
                    if (READY) begin
                        r_count <= r_count + CNT_W'(1);
                        r_ovr   <= 1'b0;
                        if (w_any) begin
                            r_code  <= w_code;
                            r_multi <= w_multi;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_any) begin
                        r_ovr <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A1    = r_code[1];
    assign A0    = r_code[0];
    assign VALID = (r_state == S_HOLD);
    assign MULTI = r_multi;
    assign OVR   = r_ovr;
    assign COUNT = r_count;

endmodule

// File: tb/tb_enc4_2_capture.sv
// Bench for enc4_2_capture: two instances (high priority / 8-bit count and
// low priority / 2-bit count) share stimulus and are compared against a model.
module tb_enc4_2_capture;

    logic CLK = 1'b0;
    logic RESET_L;
    logic E1, E0_L, I3, I2, I1, I0, READY;

    logic       hiA1, hiA0, hiValid, hiMulti, hiOvr;
    logic [7:0] hiCount;
    logic       loA1, loA0, loValid, loMulti, loOvr;
    logic [1:0] loCount;

    int compCount = 0;
    int errCount  = 0;

    logic       mValid [2];
    logic [1:0] mCode  [2];
    logic       mMulti [2];
    logic       mOvr   [2];
    int         mCount [2];
    logic [3:0] mPrev;
    int         cntMod [2] = '{256, 4};

    always #5 CLK = ~CLK;

    enc4_2_capture #(.PRIORITY_HIGH(1'b1), .CNT_W(8)) u_dutHi (
        .CLK(CLK), .RESET_L(RESET_L), .E1(E1), .E0_L(E0_L),
        .I3(I3), .I2(I2), .I1(I1), .I0(I0), .READY(READY),
        .A1(hiA1), .A0(hiA0), .VALID(hiValid), .MULTI(hiMulti),
        .OVR(hiOvr), .COUNT(hiCount)
    );

    enc4_2_capture #(.PRIORITY_HIGH(1'b0), .CNT_W(2)) u_dutLo (
        .CLK(CLK), .RESET_L(RESET_L), .E1(E1), .E0_L(E0_L),
        .I3(I3), .I2(I2), .I1(I1), .I0(I0), .READY(READY),
        .A1(loA1), .A0(loA0), .VALID(loValid), .MULTI(loMulti),
        .OVR(loOvr), .COUNT(loCount)
    );

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mValid[k] = 1'b0;
            mCode[k]  = 2'd0;
            mMulti[k] = 1'b0;
            mOvr[k]   = 1'b0;
            mCount[k] = 0;
        end
        mPrev = 4'b0000;
    endtask

    // One clock of the reference behaviour, evaluated from the inputs present before the edge.
    task automatic modelStep();
        int         edges[$];
        logic [3:0] req;
        bit         en;
        int         winner;
        req = {I3, I2, I1, I0};
        en  = E1 && !E0_L;
        for (int i = 0; i < 4; i++)
            if (en && req[i] && !mPrev[i]) edges.push_back(i);
        for (int k = 0; k < 2; k++) begin
            winner = 0;
            if (edges.size() > 0)
                winner = (k == 0) ? edges[edges.size()-1] : edges[0];
            if (!mValid[k]) begin
                if (edges.size() > 0) begin
                    mValid[k] = 1'b1;
                    mCode[k]  = 2'(winner);
                    mMulti[k] = edges.size() > 1;
                end
            end else if (READY) begin
                mCount[k] = (mCount[k] + 1) % cntMod[k];
                mOvr[k]   = 1'b0;
                if (edges.size() > 0) begin
                    mCode[k]  = 2'(winner);
                    mMulti[k] = edges.size() > 1;
                end else begin
                    mValid[k] = 1'b0;
                end
            end else if (edges.size() > 0) begin
                mOvr[k] = 1'b1;
            end
        end
        mPrev = req;
    endtask

    task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".hi.valid"}, {7'd0, hiValid}, {7'd0, mValid[0]});
        checkField({tag, ".hi.code"},  {6'd0, hiA1, hiA0}, {6'd0, mCode[0]});
        checkField({tag, ".hi.multi"}, {7'd0, hiMulti}, {7'd0, mMulti[0]});
        checkField({tag, ".hi.ovr"},   {7'd0, hiOvr}, {7'd0, mOvr[0]});
        checkField({tag, ".hi.count"}, hiCount, 8'(mCount[0]));
        checkField({tag, ".lo.valid"}, {7'd0, loValid}, {7'd0, mValid[1]});
        checkField({tag, ".lo.code"},  {6'd0, loA1, loA0}, {6'd0, mCode[1]});
        checkField({tag, ".lo.multi"}, {7'd0, loMulti}, {7'd0, mMulti[1]});
        checkField({tag, ".lo.ovr"},   {7'd0, loOvr}, {7'd0, mOvr[1]});
        checkField({tag, ".lo.count"}, {6'd0, loCount}, 8'(mCount[1]));
    endtask

    // Drive one cycle of inputs, advance the model, clock the DUTs and compare just after the edge.
    task automatic applyStimulus(input string tag, input logic e1, input logic e0l,
                                 input logic [3:0] req, input logic rdy);
        E1 = e1; E0_L = e0l; {I3, I2, I1, I0} = req; READY = rdy;
        modelStep();
        @(posedge CLK);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        $display("[TB] start");
        RESET_L = 1'b0;
        E1 = 1'b0; E0_L = 1'b1; {I3, I2, I1, I0} = 4'b0000; READY = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        RESET_L = 1'b1;

        applyStimulus("t1_capI2",    1'b1, 1'b0, 4'b0100, 1'b0);
        applyStimulus("t1_accept",   1'b1, 1'b0, 4'b0000, 1'b1);
        applyStimulus("t1_idle",     1'b1, 1'b0, 4'b0000, 1'b0);

        applyStimulus("t2_multi",    1'b1, 1'b0, 4'b1001, 1'b0);
        applyStimulus("t2_accept",   1'b1, 1'b0, 4'b0000, 1'b1);
        applyStimulus("t2_idleRdy",  1'b1, 1'b0, 4'b0000, 1'b1);

        applyStimulus("t3_e0lOff",   1'b1, 1'b1, 4'b0010, 1'b0);
        applyStimulus("t3_clear1",   1'b1, 1'b0, 4'b0000, 1'b0);
        applyStimulus("t3_e1Off",    1'b0, 1'b0, 4'b0010, 1'b0);
        applyStimulus("t3_heldHigh", 1'b1, 1'b0, 4'b0010, 1'b0);
        applyStimulus("t3_clear2",   1'b1, 1'b0, 4'b0000, 1'b0);

        applyStimulus("t4_capI2",    1'b1, 1'b0, 4'b0100, 1'b0);
        applyStimulus("t4_drop",     1'b1, 1'b0, 4'b0010, 1'b0);
        applyStimulus("t4_disHold",  1'b0, 1'b0, 4'b0000, 1'b0);
        applyStimulus("t4_b2b",      1'b1, 1'b0, 4'b1000, 1'b1);
        applyStimulus("t4_accept",   1'b1, 1'b0, 4'b0000, 1'b1);

        for (int n = 0; n < 4; n++) begin
            applyStimulus("t5_cap",  1'b1, 1'b0, 4'b0001, 1'b0);
            applyStimulus("t5_acc",  1'b1, 1'b0, 4'b0000, 1'b1);
        end
        applyStimulus("t5_capHold",  1'b1, 1'b0, 4'b0100, 1'b0);
        #2;
        RESET_L = 1'b0;
        #1;
        modelReset();
        checkOutput("t5_asyncReset");
        {I3, I2, I1, I0} = 4'b0000;
        READY = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            applyStimulus("rand",
                          1'($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
